// File: rtl/alu_exec_unit.sv
// Valid/ready ALU execution stage driven by the 3-bit ALUControl code; registered result and zero flag.
// Define ALU_EXEC_SHIFT_EN to build the iterative sll/srl/sra path (codes 100/110/111), one bit per cycle.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1
`ifdef ALU_EXEC_SHIFT_EN
      ,S_SHIFT = 2'd2
`endif
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;

   logic             w_accept;
   logic             w_load_alu;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_illegal;

`ifdef ALU_EXEC_SHIFT_EN
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [SHW-1:0]   r_cnt;
   logic [SHW-1:0]   w_shamt;
   logic [1:0]       r_shop;
   logic             w_is_shift;
   logic             w_start_shift;
   logic             w_step;
   logic             w_shift_done;
`endif

   assign in_ready  = (r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready);
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (r_state == S_HOLD);
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

   // Single-cycle datapath; for a shift it forwards src_a, which is the answer when shamt is zero.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      w_alu_res     = '0;
      w_alu_illegal = 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      w_is_shift    = 1'b0;
`endif
      case (alu_control)
         3'b000: w_alu_res = src_a + src_b;
         3'b001: w_alu_res = src_a - src_b;
         3'b010: w_alu_res = src_a & src_b;
         3'b011: w_alu_res = src_a | src_b;
         3'b101: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_EXEC_SHIFT_EN
         3'b100, 3'b110, 3'b111: begin
            w_is_shift = 1'b1;
            w_alu_res  = src_a;
         end
`endif
         default: w_alu_illegal = 1'b1;
      endcase
   end

`ifdef ALU_EXEC_SHIFT_EN
   assign w_shamt = src_b[SHW-1:0];

   // r_shop holds alu_control[1:0]: 00 sll, 10 srl, 11 sra.
   always_comb begin
      case (r_shop)
         2'b00:   w_shift_nxt = {r_shreg[WIDTH-2:0], 1'b0};
         2'b10:   w_shift_nxt = {1'b0, r_shreg[WIDTH-1:1]};
         default: w_shift_nxt = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      endcase
   end
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_load_alu    = 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      w_start_shift = 1'b0;
      w_step        = 1'b0;
      w_shift_done  = 1'b0;
`endif
      case (r_state)
         S_IDLE, S_HOLD: begin
            if (w_accept) begin
`ifdef ALU_EXEC_SHIFT_EN
               if (w_is_shift && (w_shamt != '0)) begin
                  w_state_nxt   = S_SHIFT;
                  w_start_shift = 1'b1;
               end else begin
                  w_state_nxt = S_HOLD;
                  w_load_alu  = 1'b1;
               end
`else
               w_state_nxt = S_HOLD;
               w_load_alu  = 1'b1;
`endif
            end else if ((r_state == S_HOLD) && out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
`ifdef ALU_EXEC_SHIFT_EN
         // The last step lands directly in HOLD, giving shamt+1 cycles of latency.
         S_SHIFT: begin
            w_step = 1'b1;
            if (r_cnt == SHW'(1)) begin
               w_state_nxt  = S_HOLD;
               w_shift_done = 1'b1;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_load_alu) begin
         r_result  <= w_alu_res;
         r_zero    <= (w_alu_res == '0);
         r_illegal <= w_alu_illegal;
      end
`ifdef ALU_EXEC_SHIFT_EN
      else if (w_shift_done) begin
         r_result  <= w_shift_nxt;
         r_zero    <= (w_shift_nxt == '0);
         r_illegal <= 1'b0;
      end
`endif
   end

`ifdef ALU_EXEC_SHIFT_EN
   // Reset clears the shifter so an aborted operation leaves nothing behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= '0;
         r_cnt   <= '0;
         r_shop  <= 2'b00;
      end else if (w_start_shift) begin
         r_shreg <= src_a;
         r_cnt   <= w_shamt;
         r_shop  <= alu_control[1:0];
      end else if (w_step) begin
         r_shreg <= w_shift_nxt;
         r_cnt   <= r_cnt - 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: transaction-level reference model plus directed literal checks.
// Shift checks are compiled in when ALU_EXEC_SHIFT_EN is defined; otherwise codes 100/110/111 must be illegal.
module tb_alu_exec_unit;
   localparam int W = 32;
`ifdef ALU_EXEC_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   alu_control = 3'b000;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         zero;
   logic         illegal;

   int n_vec = 0;
   int n_err = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%h, expected 0x%h", name, $time, act, exp);
      end
   endtask

   // Reference semantics of one operation: value, illegal flag and latency in cycles.
   function automatic void ref_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ill, output int lat);
      int s;
      s   = int'(b % W);
      r   = '0;
      ill = 1'b0;
      lat = 1;
      case (c)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
         default: begin
            if (SHIFT_EN) begin
               if (c == 3'd4)      r = a << s;
               else if (c == 3'd6) r = a >> s;
               else                r = $signed(a) >>> s;
               lat = s + 1;
            end else begin
               ill = 1'b1;
            end
         end
      endcase
   endfunction

   // Model state: what the consumer should observe, plus remaining cycles of a multi-cycle op.
   logic         m_valid   = 1'b0;
   logic [W-1:0] m_result  = '0;
   logic         m_zero    = 1'b0;
   logic         m_illegal = 1'b0;
   logic [W-1:0] m_pend    = '0;
   int           m_busy    = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid   = 1'b0;
         m_result  = '0;
         m_zero    = 1'b0;
         m_illegal = 1'b0;
         m_busy    = 0;
      end else begin
         logic         rdy;
         logic [W-1:0] r;
         logic         ill;
         int           lat;
         rdy = (m_busy == 0) && (!m_valid || out_ready);
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid   = 1'b1;
               m_result  = m_pend;
               m_zero    = (m_pend == 0);
               m_illegal = 1'b0;
            end
         end else if (in_valid && rdy) begin
            ref_op(alu_control, src_a, src_b, r, ill, lat);
            if (lat == 1) begin
               m_valid   = 1'b1;
               m_result  = r;
               m_zero    = (r == 0);
               m_illegal = ill;
            end else begin
               m_valid = 1'b0;
               m_busy  = lat - 1;
               m_pend  = r;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         #1;
         check("cyc_out_valid", W'(out_valid), W'(m_valid));
         check("cyc_in_ready", W'(in_ready), W'((m_busy == 0) && (!m_valid || out_ready)));
         check("cyc_result", result, m_result);
         check("cyc_zero", W'(zero), W'(m_zero));
         check("cyc_illegal", W'(illegal), W'(m_illegal));
      end
   end

   task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      @(negedge clk);
      in_valid    = 1'b1;
      alu_control = c;
      src_a       = a;
      src_b       = b;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", W'(n < 100), W'(1));
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      src_a    = $urandom;
      src_b    = $urandom;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic op_check(input string name, input logic [2:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                           input logic ei, input int elat);
      int lat;
      send(c, a, b);
      wait_out(lat);
      check({name, "_latency"}, W'(lat), W'(elat));
      check({name, "_result"}, result, er);
      check({name, "_zero"}, W'(zero), W'(ez));
      check({name, "_illegal"}, W'(illegal), W'(ei));
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] specials [5];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'h0000_0001;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      int lat;
      repeat (2) @(negedge clk);
      check("reset_out_valid", W'(out_valid), W'(0));
      check("reset_in_ready", W'(in_ready), W'(1));
      rst = 1'b0;

      op_check("add_5_7", 3'b000, 5, 7, 12, 1'b0, 1'b0, 1);
      op_check("sub_7_7", 3'b001, 7, 7, 0, 1'b1, 1'b0, 1);
      op_check("add_wrap", 3'b000, 32'hFFFF_FFFF, 1, 0, 1'b1, 1'b0, 1);
      op_check("and", 3'b010, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1);
      op_check("or", 3'b011, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, 1);
      op_check("slt_neg_lt", 3'b101, 32'hFFFF_FFFF, 1, 1, 1'b0, 1'b0, 1);
      op_check("slt_pos_ge", 3'b101, 1, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 1);

      // Backpressure, then a back-to-back accept on the releasing edge.
      @(negedge clk);
      out_ready = 1'b0;
      send(3'b000, 3, 4);
      wait_out(lat);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_result_stable", result, 7);
         check("bp_out_valid", W'(out_valid), W'(1));
         check("bp_in_ready", W'(in_ready), W'(0));
      end
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      alu_control = 3'b001;
      src_a       = 9;
      src_b       = 4;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_no_bubble", W'(out_valid), W'(1));
      check("bp_sub_result", result, 5);

      // Asynchronous reset while a result is held.
      @(negedge clk);
      out_ready = 1'b0;
      send(3'b000, 1, 1);
      wait_out(lat);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", W'(out_valid), W'(0));
      check("async_rst_in_ready", W'(in_ready), W'(1));
      check("async_rst_result", result, 0);
      check("async_rst_illegal", W'(illegal), W'(0));
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;

`ifdef ALU_EXEC_SHIFT_EN
      send(3'b100, 1, 4);
      @(negedge clk);
      check("sll_busy_in_ready", W'(in_ready), W'(0));
      check("sll_busy_out_valid", W'(out_valid), W'(0));
      wait_out(lat);
      check("sll_latency", W'(lat + 1), W'(5));
      check("sll_result", result, 32'h10);
      op_check("sra_31", 3'b111, 32'h8000_0000, 31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
      op_check("srl_31", 3'b110, 32'h8000_0000, 31, 32'h1, 1'b0, 1'b0, 32);
      op_check("sll_shamt0", 3'b100, 32'hABCD, 32, 32'hABCD, 1'b0, 1'b0, 1);
      send(3'b100, 1, 20);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_out_valid", W'(out_valid), W'(0));
      check("abort_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      rst = 1'b0;
      op_check("after_abort_add", 3'b000, 2, 3, 5, 1'b0, 1'b0, 1);
`else
      op_check("illegal_100", 3'b100, 1, 4, 0, 1'b1, 1'b1, 1);
      op_check("illegal_110", 3'b110, 32'h8000_0000, 31, 0, 1'b1, 1'b1, 1);
      op_check("illegal_111", 3'b111, 32'h8000_0000, 31, 0, 1'b1, 1'b1, 1);
      op_check("legal_after_illegal", 3'b000, 2, 3, 5, 1'b0, 1'b0, 1);
`endif

      // Randomized traffic with random backpressure; the model process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         in_valid    = 1'($urandom_range(0, 1));
         alu_control = 3'($urandom_range(0, 7));
         src_a       = pick();
         src_b       = pick();
         out_ready   = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
